pid_chn_controller: RTL and testbench
=====================================

Name: pid_chn_controller

Overview:
- Time-multiplexed PID controller for NUM_CHN motor channels; it drives the u_valid_o/u_chn_o/u_data_o stream that the PWM output processor consumes.
- On each control tick it computes one signed command per channel with a single shared multiplier.
- It then transmits all commands as a contiguous burst, channel 0 first, one channel per clock.

Parameters:
- DATA_WIDTH, 16: width of setpoint, feedback and command words (two's complement).
- NUM_CHN, 4: number of channels.
- CHN_WIDTH, 3: width of the channel index.
- GAIN_WIDTH, 16: width of the unsigned gains, fixed point with FRAC_BITS fraction bits.
- FRAC_BITS, 8: gain fraction bits (256 = 1.0).
- INT_WIDTH, 24: width of the per-channel integrator (signed).
- INT_LIM, 1_000_000: integrator clamp magnitude.
- OUT_MAX, 1500: command clamp magnitude (matches RPM_MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick_i  in  1  control-period strobe, one cycle wide.
- clr_i  in  1  synchronous clear of controller state.
- sp_i  in  NUM_CHN*DATA_WIDTH  packed signed setpoints; channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- fb_i  in  NUM_CHN*DATA_WIDTH  packed signed measured speeds, same packing.
- kp_i, ki_i, kd_i  in  GAIN_WIDTH each  gains, unsigned Q(GAIN_WIDTH-FRAC_BITS).FRAC_BITS.
- u_valid_o  out  1  command valid.
- u_chn_o  out  CHN_WIDTH  channel index of u_data_o.
- u_data_o  out  DATA_WIDTH  signed command.
- busy_o  out  1  high whenever state is not IDLE.
- overrun_o  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset: state IDLE. All integrators, previous errors and result registers = 0. Outputs u_valid_o=0, u_chn_o=0, u_data_o=0, busy_o=0, overrun_o=0.
- State machine: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> (next channel: ERR | last channel: BURST) -> IDLE.
- IDLE -> ERR occurs when tick_i=1. sp_i, fb_i and the gains are sampled per channel in that channel's ERR state; they must be held stable while busy_o=1.
- ERR:
  - e = sp - fb, computed sign-extended to DATA_WIDTH+1.
  - Itmp = I + e, clamped to ±INT_LIM.
  - d = e - e_prev, DATA_WIDTH+2 bits.
- MUL_P / MUL_I / MUL_D:
  - acc = kp*e, then acc += ki*Itmp, then acc += kd*d.
  - Gains are zero-extended to signed; acc is signed, 48 bits.
- SAT:
  - u = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf), clamped to ±OUT_MAX, stored in result[ch].
  - Anti-windup: I is updated to Itmp unless u clamped AND sign(e)==sign(unclamped u); in that case I is left unchanged.
  - e_prev = e.
- Compute time is 5 cycles per channel.
- BURST lasts NUM_CHN consecutive cycles with u_valid_o=1 and u_chn_o=0,1,..,NUM_CHN-1 carrying result[ch]. u_valid_o=0 outside BURST.
- Latency: with tick_i sampled at edge T, the first valid cycle begins at edge T+5*NUM_CHN+1 (T+21 by default). The last valid cycle begins at T+5*NUM_CHN+NUM_CHN.
- Between bursts, u_data_o/u_chn_o hold the last value; the consumer must qualify with u_valid_o.
- tick_i while busy_o=1 (including the cycle it returns to IDLE from BURST is NOT busy; IDLE accepts): the tick is ignored and overrun_o is set.
- clr_i has priority over tick_i in every state. It returns the FSM to IDLE, zeroes integrators, e_prev and results, and clears overrun_o. u_valid_o=0 from the next cycle; any burst in progress is truncated. A tick in the same cycle as clr_i is dropped.
- rst asserted mid-operation: all state and outputs return to reset values immediately (asynchronously).

Decomposition:
- Shared package pid_pkg holds:
  - the state encoding (IDLE, ERR, MUL_P, MUL_I, MUL_D, SAT, BURST);
  - widths ACC_WIDTH=48 and ERR_WIDTH=DATA_WIDTH+1;
  - the default OUT_MAX and INT_LIM.
- One sub-module, pid_sat: a parameterised signed clamp (input width, output width, limit) used for both the integrator and the output clamp.
- The multiply-accumulate stays inline.

Test Plan:
- Proportional: kp=256, ki=kd=0, sp={1000,700,500,150} (ch3..ch0), fb=0, one tick -> four valid cycles starting at T+21 with chn 0..3 and data 150, 500, 700, 1000.
- Clamp: kp=256, sp0=2000 then sp0=-2000 (fb0=0) on successive ticks -> ch0 data 1500 (0x05DC), then -1500 (0xFA24).
- Integral: kp=0, ki=128, sp0=100, fb0=0, three ticks -> ch0 data 50, 100, 150. Then clr_i and one more tick -> 50.
- Derivative: kp=ki=0, kd=256, fb0=0, sp0=0 for tick 1 and 100 for ticks 2 and 3 -> ch0 data 0, 100, 0.
- Overrun: tick at T, second tick at T+10 -> only one burst. overrun_o=1 from T+11, held until clr_i, then 0.
- Reset mid-burst: assert rst during the second valid cycle -> u_valid_o=0 and busy_o=0 immediately. After release, the next tick produces a full 4-cycle burst with integrators at 0.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared state encoding and width/limit defaults for the PID channel controller.
package pid_pkg;
   typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SAT, BURST} state_t;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int ERR_WIDTH = DEF_DATA_WIDTH + 1;
   localparam int ACC_WIDTH = 48;
   localparam int DEF_OUT_MAX = 1500;
   localparam int DEF_INT_LIM = 1_000_000;
endpackage

// File: rtl/pid_sat.sv
// pid_sat: symmetric signed clamp to +/-LIM with width reduction.
module pid_sat #(
   parameter int IW  = 48,
   parameter int OW  = 16,
   parameter int LIM = 1500
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout
);
   localparam logic signed [IW-1:0] HI = IW'(LIM);
   localparam logic signed [IW-1:0] LO = -HI;
   assign dout = din > HI ? OW'(HI) : din < LO ? OW'(LO) : OW'(din);
endmodule

// File: rtl/pid_chn_controller.sv
// pid_chn_controller: time-multiplexed PID over NUM_CHN channels sharing one multiplier,
// results streamed as a contiguous burst after every channel is computed.
module pid_chn_controller
   import pid_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CHN    = 4,
   parameter int CHN_WIDTH  = 3,
   parameter int GAIN_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int INT_WIDTH  = 24,
   parameter int INT_LIM    = DEF_INT_LIM,
   parameter int OUT_MAX    = DEF_OUT_MAX
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick_i,
   input  logic                          clr_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] sp_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] fb_i,
   input  logic [GAIN_WIDTH-1:0]         kp_i,
   input  logic [GAIN_WIDTH-1:0]         ki_i,
   input  logic [GAIN_WIDTH-1:0]         kd_i,
   output logic                          u_valid_o,
   output logic [CHN_WIDTH-1:0]          u_chn_o,
   output logic [DATA_WIDTH-1:0]         u_data_o,
   output logic                          busy_o,
   output logic                          overrun_o
);
   localparam int CW = NUM_CHN > 1 ? $clog2(NUM_CHN) : 1;
   localparam int EW = DATA_WIDTH + 1;
   localparam int DW = DATA_WIDTH + 2;
   localparam int PW = GAIN_WIDTH + 1 + INT_WIDTH;

   state_t state;
   logic [CW-1:0] ch;
   logic signed [EW-1:0] e, e_c;
   logic signed [DW-1:0] d, d_c;
   logic signed [INT_WIDTH-1:0] itmp, itmp_c, mul_x;
   logic signed [INT_WIDTH:0] i_sum;
   logic signed [ACC_WIDTH-1:0] acc, u_shift;
   logic signed [PW-1:0] prod;
   logic [GAIN_WIDTH-1:0] mul_g;
   logic signed [DATA_WIDTH-1:0] sp_c, fb_c, u_c;
   logic last, hold_i;
   logic signed [INT_WIDTH-1:0]  integ  [NUM_CHN];
   logic signed [EW-1:0]         e_prev [NUM_CHN];
   logic signed [DATA_WIDTH-1:0] result [NUM_CHN];

   assign sp_c  = sp_i[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
   assign fb_c  = fb_i[int'(ch)*DATA_WIDTH +: DATA_WIDTH];
   assign e_c   = EW'(sp_c) - EW'(fb_c);
   assign i_sum = (INT_WIDTH+1)'(integ[ch]) + (INT_WIDTH+1)'(e_c);
   assign d_c   = DW'(e_c) - DW'(e_prev[ch]);
   assign last  = ch == CW'(NUM_CHN - 1);

   pid_sat #(.IW(INT_WIDTH+1), .OW(INT_WIDTH), .LIM(INT_LIM)) u_isat (.din(i_sum), .dout(itmp_c));

   // One multiplier serves all three terms; gains are unsigned so a zero MSB makes them signed.
   assign mul_g = state == MUL_P ? kp_i : state == MUL_I ? ki_i : kd_i;
   assign mul_x = state == MUL_P ? INT_WIDTH'(e) : state == MUL_I ? itmp : INT_WIDTH'(d);
   assign prod  = $signed({1'b0, mul_g}) * mul_x;

   assign u_shift = acc >>> FRAC_BITS;
   pid_sat #(.IW(ACC_WIDTH), .OW(DATA_WIDTH), .LIM(OUT_MAX)) u_osat (.din(u_shift), .dout(u_c));

   // Freeze the integrator only when the output saturates in the direction the error pushes.
   assign hold_i = (u_shift != ACC_WIDTH'(u_c)) && (e[EW-1] == u_shift[ACC_WIDTH-1]);
   assign busy_o = state != IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ch        <= '0;
         e         <= '0;
         d         <= '0;
         itmp      <= '0;
         acc       <= '0;
         u_valid_o <= 1'b0;
         u_chn_o   <= '0;
         u_data_o  <= '0;
         overrun_o <= 1'b0;
         for (int i = 0; i < NUM_CHN; i++) begin
            integ[i]  <= '0;
            e_prev[i] <= '0;
            result[i] <= '0;
         end
      end else if (clr_i) begin
         state     <= IDLE;
         ch        <= '0;
         u_valid_o <= 1'b0;
         overrun_o <= 1'b0;
         for (int i = 0; i < NUM_CHN; i++) begin
            integ[i]  <= '0;
            e_prev[i] <= '0;
            result[i] <= '0;
         end
      end else begin
         u_valid_o <= 1'b0;
         if (tick_i && state != IDLE) overrun_o <= 1'b1;
         case (state)
            IDLE: if (tick_i) state <= ERR;
            ERR: begin
               e     <= e_c;
               d     <= d_c;
               itmp  <= itmp_c;
               state <= MUL_P;
            end
            MUL_P: begin
               acc   <= ACC_WIDTH'(prod);
               state <= MUL_I;
            end
            MUL_I: begin
               acc   <= acc + ACC_WIDTH'(prod);
               state <= MUL_D;
            end
            MUL_D: begin
               acc   <= acc + ACC_WIDTH'(prod);
               state <= SAT;
            end
            SAT: begin
               result[ch] <= u_c;
               e_prev[ch] <= e;
               if (!hold_i) integ[ch] <= itmp;
               ch    <= last ? '0 : ch + 1'b1;
               state <= last ? BURST : ERR;
            end
            BURST: begin
               u_valid_o <= 1'b1;
               u_chn_o   <= CHN_WIDTH'(ch);
               u_data_o  <= result[ch];
               ch        <= last ? '0 : ch + 1'b1;
               state     <= last ? IDLE : BURST;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pid_chn_controller.sv
// tb_pid_chn_controller: randomized and directed checks against an arithmetic PID reference model.
module tb_pid_chn_controller;
   logic clk = 0, rst = 1, tick_i = 0, clr_i = 0;
   logic signed [15:0] sp_a [4], fb_a [4];
   logic [63:0] sp_i, fb_i;
   logic [15:0] kp_i = 0, ki_i = 0, kd_i = 0;
   logic u_valid_o, busy_o, overrun_o;
   logic [2:0] u_chn_o;
   logic [15:0] u_data_o;
   int vectors = 0, miscompares = 0;
   int first_k, last_k, nv;
   logic [15:0] cap_d [4];
   logic [2:0] cap_c [4];
   longint m_i [4], m_ep [4];
   logic [15:0] exp_d [4];

   assign sp_i = {sp_a[3], sp_a[2], sp_a[1], sp_a[0]};
   assign fb_i = {fb_a[3], fb_a[2], fb_a[1], fb_a[0]};

   always #5 clk = ~clk;

   pid_chn_controller dut (
      .clk(clk), .rst(rst), .tick_i(tick_i), .clr_i(clr_i), .sp_i(sp_i), .fb_i(fb_i),
      .kp_i(kp_i), .ki_i(ki_i), .kd_i(kd_i), .u_valid_o(u_valid_o), .u_chn_o(u_chn_o),
      .u_data_o(u_data_o), .busy_o(busy_o), .overrun_o(overrun_o)
   );

   function automatic longint clamp(longint v, longint l);
      return v > l ? l : v < -l ? -l : v;
   endfunction

   task automatic model_clear();
      for (int n = 0; n < 4; n++) begin
         m_i[n] = 0;
         m_ep[n] = 0;
      end
   endtask

   task automatic model_tick();
      for (int n = 0; n < 4; n++) begin
         longint e, it, dd, acc, uf, u;
         e   = longint'(sp_a[n]) - longint'(fb_a[n]);
         it  = clamp(m_i[n] + e, 1000000);
         dd  = e - m_ep[n];
         acc = longint'(kp_i) * e + longint'(ki_i) * it + longint'(kd_i) * dd;
         uf  = acc >>> 8;
         u   = clamp(uf, 1500);
         if (!(u != uf && ((e < 0) == (uf < 0)))) m_i[n] = it;
         m_ep[n] = e;
         exp_d[n] = 16'(u);
      end
   endtask

   task automatic set_inputs(input int s0, input int s1, input int s2, input int s3);
      sp_a[0] = 16'(s0); sp_a[1] = 16'(s1); sp_a[2] = 16'(s2); sp_a[3] = 16'(s3);
      for (int n = 0; n < 4; n++) fb_a[n] = 0;
   endtask

   task automatic do_clr();
      @(negedge clk) clr_i = 1;
      @(negedge clk) clr_i = 0;
      model_clear();
   endtask

   // Pulse tick then watch a bounded 40-cycle window, recording the burst.
   task automatic run_tick();
      @(negedge clk) tick_i = 1;
      @(negedge clk) tick_i = 0;
      first_k = -1; last_k = -1; nv = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (u_valid_o) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            if (nv < 4) begin
               cap_d[nv] = u_data_o;
               cap_c[nv] = u_chn_o;
            end
            nv++;
         end
      end
   endtask

   task automatic check_burst(input string name);
      vectors++;
      if (nv !== 4 || first_k !== 21 || last_k !== 24) begin
         miscompares++;
         $display("FAIL %s timing: count=%0d first=%0d last=%0d, required 4/21/24", name, nv, first_k, last_k);
      end
      for (int n = 0; n < 4; n++) begin
         vectors++;
         if (cap_c[n] !== 3'(n) || cap_d[n] !== exp_d[n]) begin
            miscompares++;
            $display("FAIL %s ch%0d: chn=%0d data=%0d, required chn=%0d data=%0d",
                     name, n, cap_c[n], $signed(cap_d[n]), n, $signed(exp_d[n]));
         end
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({u_valid_o, u_chn_o, u_data_o, busy_o, overrun_o} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset outputs: %h, required 0", {u_valid_o, u_chn_o, u_data_o, busy_o, overrun_o});
      end
   endtask

   task automatic test_proportional();
      do_clr();
      kp_i = 256; ki_i = 0; kd_i = 0;
      set_inputs(150, 500, 700, 1000);
      model_tick();
      run_tick();
      check_burst("proportional");
      vectors++;
      if (cap_d[0] !== 16'd150 || cap_d[3] !== 16'd1000) begin
         miscompares++;
         $display("FAIL proportional values: ch0=%0d ch3=%0d, required 150 1000", cap_d[0], cap_d[3]);
      end
   endtask

   task automatic test_clamp();
      do_clr();
      kp_i = 256; ki_i = 0; kd_i = 0;
      set_inputs(2000, 0, 0, 0);
      model_tick();
      run_tick();
      check_burst("clamp_pos");
      vectors++;
      if (cap_d[0] !== 16'h05DC) begin
         miscompares++;
         $display("FAIL clamp_pos: %h, required 05DC", cap_d[0]);
      end
      set_inputs(-2000, 0, 0, 0);
      model_tick();
      run_tick();
      check_burst("clamp_neg");
      vectors++;
      if (cap_d[0] !== 16'hFA24) begin
         miscompares++;
         $display("FAIL clamp_neg: %h, required FA24", cap_d[0]);
      end
   endtask

   task automatic test_integral();
      do_clr();
      kp_i = 0; ki_i = 128; kd_i = 0;
      set_inputs(100, 0, 0, 0);
      for (int t = 0; t < 3; t++) begin
         model_tick();
         run_tick();
         check_burst("integral");
         vectors++;
         if (cap_d[0] !== 16'(50 * (t + 1))) begin
            miscompares++;
            $display("FAIL integral tick%0d: %0d, required %0d", t, cap_d[0], 50 * (t + 1));
         end
      end
      do_clr();
      model_tick();
      run_tick();
      check_burst("integral_clr");
      vectors++;
      if (cap_d[0] !== 16'd50) begin
         miscompares++;
         $display("FAIL integral_clr: %0d, required 50", cap_d[0]);
      end
   endtask

   task automatic test_derivative();
      logic [15:0] want [3];
      want[0] = 0; want[1] = 100; want[2] = 0;
      do_clr();
      kp_i = 0; ki_i = 0; kd_i = 256;
      for (int t = 0; t < 3; t++) begin
         set_inputs(t == 0 ? 0 : 100, 0, 0, 0);
         model_tick();
         run_tick();
         check_burst("derivative");
         vectors++;
         if (cap_d[0] !== want[t]) begin
            miscompares++;
            $display("FAIL derivative tick%0d: %0d, required %0d", t, cap_d[0], want[t]);
         end
      end
   endtask

   task automatic test_random();
      do_clr();
      for (int t = 0; t < 12; t++) begin
         kp_i = 16'($urandom_range(0, t < 6 ? 1024 : 65535));
         ki_i = 16'($urandom_range(0, t < 6 ? 512 : 65535));
         kd_i = 16'($urandom_range(0, t < 6 ? 512 : 65535));
         for (int n = 0; n < 4; n++) begin
            sp_a[n] = t < 6 ? 16'($signed($urandom_range(0, 4000)) - 2000) : 16'($urandom);
            fb_a[n] = t < 6 ? 16'($signed($urandom_range(0, 4000)) - 2000) : 16'($urandom);
         end
         model_tick();
         run_tick();
         check_burst("random");
      end
   endtask

   task automatic test_overrun();
      int cnt;
      do_clr();
      kp_i = 256; ki_i = 0; kd_i = 0;
      set_inputs(10, 20, 30, 40);
      cnt = 0;
      @(negedge clk) tick_i = 1;
      @(negedge clk) tick_i = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (u_valid_o) cnt++;
         if (k == 10) begin
            vectors++;
            if (overrun_o !== 1'b0 || busy_o !== 1'b1) begin
               miscompares++;
               $display("FAIL overrun_pre: overrun=%b busy=%b, required 0 1", overrun_o, busy_o);
            end
            tick_i = 1;
         end
         if (k == 11) begin
            tick_i = 0;
            vectors++;
            if (overrun_o !== 1'b1) begin
               miscompares++;
               $display("FAIL overrun_set: %b, required 1", overrun_o);
            end
         end
      end
      vectors++;
      if (cnt !== 4 || overrun_o !== 1'b1 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_burst: valid=%0d overrun=%b busy=%b, required 4 1 0", cnt, overrun_o, busy_o);
      end
      do_clr();
      vectors++;
      if (overrun_o !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_clr: %b, required 0", overrun_o);
      end
   endtask

   task automatic test_clr_priority();
      int cnt;
      cnt = 0;
      @(negedge clk) begin tick_i = 1; clr_i = 1; end
      @(negedge clk) begin tick_i = 0; clr_i = 0; end
      model_clear();
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (u_valid_o || busy_o) cnt++;
      end
      vectors++;
      if (cnt !== 0) begin
         miscompares++;
         $display("FAIL clr_priority: active cycles=%0d, required 0", cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_clr();
      kp_i = 0; ki_i = 128; kd_i = 0;
      set_inputs(100, 200, 300, 400);
      @(negedge clk) tick_i = 1;
      @(negedge clk) tick_i = 0;
      for (int k = 1; k <= 22; k++) @(negedge clk);
      vectors++;
      if (u_valid_o !== 1'b1 || u_chn_o !== 3'd1) begin
         miscompares++;
         $display("FAIL reset_mid_pre: valid=%b chn=%0d, required 1 1", u_valid_o, u_chn_o);
      end
      rst = 1;
      #1;
      vectors++;
      if (u_valid_o !== 1'b0 || busy_o !== 1'b0 || u_data_o !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b busy=%b data=%0d, required 0 0 0", u_valid_o, busy_o, u_data_o);
      end
      @(negedge clk) rst = 0;
      model_clear();
      model_tick();
      run_tick();
      check_burst("reset_mid_after");
   endtask

   initial begin
      for (int n = 0; n < 4; n++) begin
         sp_a[n] = 0;
         fb_a[n] = 0;
      end
      model_clear();
      repeat (2) @(negedge clk);
      test_reset();
      rst = 0;
      @(negedge clk);
      test_reset();
      test_proportional();
      test_clamp();
      test_integral();
      test_derivative();
      test_random();
      test_overrun();
      test_clr_priority();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
